pattern_det_ctrl: RTL and testbench
===================================

// Module: pattern_det_ctrl
// PURPOSE
//  Programmable serial pattern-detection controller: configures a bit pattern of 1..MAX_LEN bits,
//  arms detection on a serial bit stream, and counts matches.
//  Generalises the fixed-pattern serial detectors in the FSM library into one runtime-configured block.
//  Sits between a config master (valid/ready) and a serial data source; reports match pulses and a done flag.
// PARAMETERS
//  MAX_LEN  8  maximum pattern length in bits (>=2)
//  CNT_W    8  width of match counter and target
//  LEN_W    $clog2(MAX_LEN+1)  localparam; width of cfg_len
// PORTS
//  clk          in   1        single clock, all logic on posedge
//  reset_n      in   1        asynchronous, active-low reset
//  cfg_valid    in   1        config request
//  cfg_ready    out  1        1 only in IDLE; config is accepted when cfg_valid & cfg_ready
//  cfg_pattern  in   MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
//  cfg_len      in   LEN_W    pattern length
//  cfg_overlap  in   1        1 = overlapping matches allowed
//  cfg_target   in   CNT_W    match count that ends the run; 0 = free-run (never DONE)
//  cfg_err      out  1        1-cycle pulse: accepted handshake with illegal cfg_len
//  start        in   1        arm detection
//  stop         in   1        abort and return to IDLE
//  din          in   1        serial data bit
//  din_valid    in   1        din qualifier; only qualified bits are sampled
//  match        out  1        1-cycle pulse per detected pattern
//  match_cnt    out  CNT_W    matches since last start; saturates at all-ones
//  busy         out  1        1 in ARMED
//  done         out  1        1 in DONE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except cfg_ready=1; pattern regs, len, history and fill cleared.
//  States:
//   IDLE  - cfg_ready=1.
//           On cfg_valid: if 1<=cfg_len<=MAX_LEN, latch pattern/len/overlap/target.
//           Otherwise pulse cfg_err next cycle and keep the old config.
//           start -> ARMED.
//   ARMED - sample bits. stop -> IDLE.
//           On the cycle the match taking match_cnt to cfg_target (target!=0) is registered -> DONE.
//   DONE  - done=1; sampling halted.
//           start -> ARMED (re-arm); stop -> IDLE.
//  start (from IDLE or DONE) clears match_cnt, history, fill; the config is unchanged.
//  start is ignored in ARMED. start & stop in the same cycle: stop wins.
//  stop leaves match_cnt holding its value.
//  cfg_valid outside IDLE: cfg_ready=0, nothing latched, no cfg_err.
//  Detection (ARMED, din_valid=1):
//   nxt_hist = {hist[MAX_LEN-2:0], din}; fill saturates at cfg_len.
//   hit = (fill+1 >= len) & (nxt_hist[len-1:0] == pattern[len-1:0]).
//   Latency: match is registered, high the cycle after the completing din_valid sample.
//   match_cnt updates in that same cycle.
//  Overlap: on hit, fill keeps its value if cfg_overlap=1; fill=0 if cfg_overlap=0
//   (the next match needs len fresh bits).
//  din_valid=0: no shift, no fill change, no match.
//  Length 1 is legal: every qualified bit equal to pattern[0] matches.
//  A hit on the cycle stop is sampled is discarded (no match pulse, no count).
//  Reset mid-run: immediate return to the reset state; no pulses are emitted.
// STRUCTURE
//  Package seq_det_pkg:
//   - typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_DONE} det_state_t
//   - function len_ok(len, max)
//  Sub-module pattern_matcher: history shift register, fill counter and masked compare.
//   Inputs: shift_en, clr, din, pattern, len, overlap. Output: combinational hit.
//  Top level: FSM, config registers, handshake, counter and output registers.
// TESTING
//  1 Reset: hold reset_n=0 mid-ARMED -> match=0, match_cnt=0, busy=0, done=0, cfg_ready=1.
//  2 Config 3'b101, len=3, overlap=1, target=0; stream 1,0,1,0,1
//    -> match after the 3rd and 5th bits; match_cnt=2.
//  3 Same stream with overlap=0 -> single match after the 3rd bit; match_cnt=1.
//  4 target=2, pattern 2'b11, stream 1,1,1,1,1 (overlap=1)
//    -> match after bits 2 and 3; DONE the cycle of the 2nd match; bits 4-5 ignored; match_cnt=2.
//  5 cfg_len=0 and cfg_len=MAX_LEN+1 in IDLE -> cfg_err pulses, old config retained.
//    cfg_valid while ARMED -> cfg_ready=0, no latch.
//  6 din_valid gaps inside 1,0,1 (0 bubbles between bits) -> still one match.
//    start & stop same cycle in DONE -> IDLE, match_cnt held.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM state type and config helpers for the pattern detection controller
package seq_det_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_DONE} det_state_t;
    function automatic logic len_ok(input int unsigned len, input int unsigned max);
        return (len >= 1) && (len <= max);
    endfunction
endpackage

// File: rtl/pattern_matcher.sv
// pattern_matcher: serial history shift register, fill counter and length-masked pattern compare
module pattern_matcher #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               shift_en,
    input  logic               clr,
    input  logic               din,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               hit
);
    logic [MAX_LEN-1:0] hist_q, hist_d, mask;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [LEN_W:0]     fill_inc;
    logic               full;
    always_comb begin
        hist_d   = {hist_q[MAX_LEN-2:0], din};
        fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
        full     = fill_inc >= {1'b0, len};
        // shifting by len == MAX_LEN yields zero, so the mask becomes all ones
        mask     = ~({MAX_LEN{1'b1}} << len);
        hit      = shift_en && full && (((hist_d ^ pattern) & mask) == '0);
        fill_d   = (hit && !overlap) ? '0 : full ? len : fill_inc[LEN_W-1:0];
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_en) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end
endmodule

// File: rtl/pattern_det_ctrl.sv
// pattern_det_ctrl: runtime-configured serial pattern detector with valid/ready config,
// arm/stop control and a saturating match counter
module pattern_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    output logic               cfg_err,
    input  logic               start,
    input  logic               stop,
    input  logic               din,
    input  logic               din_valid,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
);
    det_state_t         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q, match_q, err_q;
    logic [CNT_W-1:0]   tgt_q, cnt_q, cnt_inc;
    logic               acc, cfg_ok, start_ok, shift_en, hit, hit_ok;
    always_comb begin
        acc      = cfg_valid && (state_q == ST_IDLE);
        cfg_ok   = len_ok(32'(cfg_len), MAX_LEN);
        start_ok = start && !stop && (state_q != ST_ARMED);
        shift_en = (state_q == ST_ARMED) && din_valid;
        hit_ok   = hit && !stop;
        cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end
    pattern_matcher #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_matcher (
        .clk      (clk),
        .reset_n  (reset_n),
        .shift_en (shift_en),
        .clr      (start_ok),
        .din      (din),
        .pattern  (pat_q),
        .len      (len_q),
        .overlap  (ovl_q),
        .hit      (hit)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else state_q <= state_d;
    end
    // stop dominates start; DONE is entered on the same edge that registers the target match
    always_comb begin
        state_d = state_q;
        if (stop) state_d = ST_IDLE;
        else if (start_ok) state_d = ST_ARMED;
        else if ((state_q == ST_ARMED) && hit_ok && (tgt_q != '0) && (cnt_inc == tgt_q)) state_d = ST_DONE;
    end
    always_comb begin
        cfg_ready = state_q == ST_IDLE;
        busy      = state_q == ST_ARMED;
        done      = state_q == ST_DONE;
        match     = match_q;
        match_cnt = cnt_q;
        cfg_err   = err_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            tgt_q   <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            match_q <= hit_ok;
            err_q   <= acc && !cfg_ok;
            if (start_ok) cnt_q <= '0;
            else if (hit_ok) cnt_q <= cnt_inc;
            if (acc && cfg_ok) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
                ovl_q <= cfg_overlap;
                tgt_q <= cfg_target;
            end
        end
    end
endmodule

// File: tb/tb_pattern_det_ctrl.sv
// tb_pattern_det_ctrl: table-driven directed bench for pattern_det_ctrl plus async reset sequence
module tb_pattern_det_ctrl;
    logic       clk = 1'b0, reset_n = 1'b0;
    logic       cfg_valid = 1'b0, cfg_ready, cfg_overlap = 1'b0, cfg_err;
    logic [7:0] cfg_pattern = '0, cfg_target = '0, match_cnt;
    logic [3:0] cfg_len = '0;
    logic       start = 1'b0, stop = 1'b0, din = 1'b0, din_valid = 1'b0;
    logic       match, busy, done;
    int         errors = 0, checks = 0;

    pattern_det_ctrl dut (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_target(cfg_target), .cfg_err(cfg_err), .start(start), .stop(stop),
        .din(din), .din_valid(din_valid), .match(match), .match_cnt(match_cnt),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic [7:0] tgt;
        logic       st, sp, dv, d;
        logic       m;
        logic [7:0] cnt;
        logic       bz, dn, err;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic m, input logic [7:0] cnt,
                              input logic bz, input logic dn, input logic err);
        chk({tag, " match"}, int'(match), int'(m));
        chk({tag, " match_cnt"}, int'(match_cnt), int'(cnt));
        chk({tag, " busy"}, int'(busy), int'(bz));
        chk({tag, " done"}, int'(done), int'(dn));
        chk({tag, " cfg_ready"}, int'(cfg_ready), int'(!(bz || dn)));
        chk({tag, " cfg_err"}, int'(cfg_err), int'(err));
    endtask

    function automatic void add(input logic cv, input logic [7:0] pat, input logic [3:0] len,
                                input logic ovl, input logic [7:0] tgt,
                                input logic st, input logic sp, input logic dv, input logic d,
                                input logic m, input logic [7:0] cnt,
                                input logic bz, input logic dn, input logic err);
        vec_t v;
        v.cv = cv; v.pat = pat; v.len = len; v.ovl = ovl; v.tgt = tgt;
        v.st = st; v.sp = sp; v.dv = dv; v.d = d;
        v.m = m; v.cnt = cnt; v.bz = bz; v.dn = dn; v.err = err;
        tbl.push_back(v);
    endfunction

    function automatic void b(input logic dv, input logic d, input logic m,
                              input logic [7:0] cnt, input logic bz, input logic dn);
        add(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, dv, d, m, cnt, bz, dn, 1'b0);
    endfunction

    function automatic void s();
        add(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic void p(input logic [7:0] cnt);
        add(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, cnt, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic void c(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                              input logic [7:0] tgt, input logic [7:0] cnt, input logic err);
        add(1'b1, pat, len, ovl, tgt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt, 1'b0, 1'b0, err);
    endfunction

    initial begin
        // pattern 101, overlapping, free-run
        c(8'h05, 4'd3, 1'b1, 8'd0, 8'd0, 1'b0);
        s();
        b(1,1, 0,0,1,0); b(1,0, 0,0,1,0); b(1,1, 1,1,1,0); b(1,0, 0,1,1,0); b(1,1, 1,2,1,0);
        p(8'd2);
        // same stream, non-overlapping
        c(8'h05, 4'd3, 1'b0, 8'd0, 8'd2, 1'b0);
        s();
        b(1,1, 0,0,1,0); b(1,0, 0,0,1,0); b(1,1, 1,1,1,0); b(1,0, 0,1,1,0); b(1,1, 0,1,1,0);
        p(8'd1);
        // din_valid bubbles inside 1,0,1
        s();
        b(1,1, 0,0,1,0); b(0,0, 0,0,1,0); b(1,0, 0,0,1,0); b(0,1, 0,0,1,0); b(1,1, 1,1,1,0);
        // hit on the stop cycle is discarded
        b(1,1, 0,1,1,0); b(1,0, 0,1,1,0);
        add(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
        // target 2, pattern 11
        c(8'h03, 4'd2, 1'b1, 8'd2, 8'd1, 1'b0);
        s();
        b(1,1, 0,0,1,0); b(1,1, 1,1,1,0); b(1,1, 1,2,0,1); b(1,1, 0,2,0,1); b(1,1, 0,2,0,1);
        // start and stop together in DONE
        add(1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
        // illegal lengths rejected, old config kept
        c(8'h00, 4'd0, 1'b0, 8'd1, 8'd2, 1'b1);
        b(0,0, 0,2,0,0);
        c(8'h00, 4'd9, 1'b0, 8'd1, 8'd2, 1'b1);
        s();
        add(1'b1, 8'h01, 4'd2, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        b(1,1, 0,0,1,0); b(1,1, 1,1,1,0); b(1,1, 1,2,0,1);
        p(8'd2);
        // maximum length pattern 10100101
        c(8'hA5, 4'd8, 1'b1, 8'd0, 8'd2, 1'b0);
        s();
        b(1,1, 0,0,1,0); b(1,0, 0,0,1,0); b(1,1, 0,0,1,0); b(1,0, 0,0,1,0);
        b(1,0, 0,0,1,0); b(1,1, 0,0,1,0); b(1,0, 0,0,1,0); b(1,1, 1,1,1,0);
        p(8'd1);
        // length 1
        c(8'h01, 4'd1, 1'b0, 8'd0, 8'd1, 1'b0);
        s();
        b(1,1, 1,1,1,0); b(1,0, 0,1,1,0); b(1,1, 1,2,1,0); b(1,1, 1,3,1,0);

        repeat (2) @(posedge clk);
        #1 expect_out("reset", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        foreach (tbl[i]) begin
            @(negedge clk);
            cfg_valid = tbl[i].cv; cfg_pattern = tbl[i].pat; cfg_len = tbl[i].len;
            cfg_overlap = tbl[i].ovl; cfg_target = tbl[i].tgt;
            start = tbl[i].st; stop = tbl[i].sp; din_valid = tbl[i].dv; din = tbl[i].d;
            @(posedge clk);
            #1 expect_out($sformatf("row%0d", i), tbl[i].m, tbl[i].cnt, tbl[i].bz, tbl[i].dn, tbl[i].err);
        end
        // asynchronous reset while ARMED with a match pulse outstanding
        @(negedge clk);
        cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; din_valid = 1'b1; din = 1'b1;
        #2 reset_n = 1'b0;
        #1 expect_out("async_rst", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 expect_out("held_rst", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #1 expect_out("post_rst", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
